// File: rtl/decode_stage.sv
// Instruction decode stage: latches IF_ID, reads operands from the 32x32 register
// file with writeback bypass, and registers ID_EX. Squashes on taken branch, stops after HLT.
module decode_stage #(
    parameter bit         ZERO_REG = 1'b1,
    parameter logic [5:0] HALT_OP  = 6'b001101,
    parameter logic [5:0] NOP_OP   = 6'b001110
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [63:0]  IF_ID,
    input  logic [70:0]  EX_WB,
    output logic [145:0] ID_EX,
    output logic         halted,
    input  logic [4:0]   dbg_addr,
    output logic [31:0]  dbg_data
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t         state_reg, state_next;
    logic [145:0]   id_ex_reg, id_ex_next;
    logic [31:0]    rf_reg [32];
    logic [31:0]    wr_en;

    logic           br_taken, wb_en;
    logic [4:0]     wb_reg;
    logic [31:0]    wb_data;
    logic [31:0]    pc, instr;
    logic [5:0]     op;
    logic [4:0]     rs, rt, rd, shamt, dest;
    logic [31:0]    imm, rs_data, rt_data;
    logic           reg_write;

    // The branch target is consumed by fetch; decode only needs the taken flag.
    logic [31:0]    unused_target;
    assign unused_target = EX_WB[63:32];

    assign br_taken = EX_WB[70];
    assign wb_en    = EX_WB[69];
    assign wb_reg   = EX_WB[68:64];
    assign wb_data  = EX_WB[31:0];

    assign pc    = IF_ID[63:32];
    assign instr = IF_ID[31:0];
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign imm   = {{21{instr[10]}}, instr[10:0]};
    assign dest  = (op == 6'b001011) ? rt : rd;
    assign reg_write = (op <= 6'd7) || (op == 6'b001010) || (op == 6'b001011) || (op == 6'b001100);

    function automatic logic [31:0] rf_read(input logic [4:0] addr);
        return (ZERO_REG && addr == 5'd0) ? 32'd0 : rf_reg[addr];
    endfunction

    // Writeback in the same cycle as the read wins over the stored value.
    function automatic logic [31:0] operand(input logic [4:0] addr);
        if (wb_en && wb_reg == addr && !(ZERO_REG && addr == 5'd0))
            return wb_data;
        return rf_read(addr);
    endfunction

    assign rs_data  = operand(rs);
    assign rt_data  = operand(rt);
    assign dbg_data = rf_read(dbg_addr);

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_wr_en
            assign wr_en[gi] = wb_en && (wb_reg == 5'(gi)) && !(ZERO_REG && gi == 0);
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_reg[i] <= 32'd0;
        end else begin
            for (int i = 0; i < 32; i++)
                if (wr_en[i]) rf_reg[i] <= wb_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        id_ex_next = '0;
        if (state_reg == RUN && !br_taken) begin
            if (op == HALT_OP) begin
                id_ex_next = {1'b1, 1'b0, op, dest, shamt, imm, rt_data, rs_data, pc};
                state_next = HALTED;
            end else if (op != NOP_OP && op <= 6'd12) begin
                id_ex_next = {1'b1, reg_write, op, dest, shamt, imm, rt_data, rs_data, pc};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
            id_ex_reg <= '0;
        end else begin
            state_reg <= state_next;
            id_ex_reg <= id_ex_next;
        end
    end

    assign ID_EX  = id_ex_reg;
    assign halted = (state_reg == HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference model pushes expected ID_EX per
// driven instruction, popped and compared one edge later.
module tb_decode_stage;

    logic         clock;
    logic         reset;
    logic [63:0]  IF_ID;
    logic [70:0]  EX_WB;
    logic [145:0] ID_EX;
    logic         halted;
    logic [4:0]   dbg_addr;
    logic [31:0]  dbg_data;

    int errors = 0;
    int checks = 0;

    logic [145:0] exp_q [$];
    logic [31:0]  m_rf [32];
    logic         m_halted;

    localparam logic [31:0] NOP = 32'h3800_0000;
    localparam logic [31:0] HLT = 32'h3400_0000;

    decode_stage dut (
        .clock    (clock),
        .reset    (reset),
        .IF_ID    (IF_ID),
        .EX_WB    (EX_WB),
        .ID_EX    (ID_EX),
        .halted   (halted),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [145:0] got, input logic [145:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 5'd0, 6'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [10:0] imm);
        return {op, rs, rt, 5'd0, imm};
    endfunction

    function automatic logic [70:0] wb(input logic br, input logic en, input logic [4:0] r,
                                       input logic [31:0] target, input logic [31:0] data);
        return {br, en, r, target, data};
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] r, input logic [70:0] exwb);
        if (exwb[69] && exwb[68:64] == r && r != 5'd0) return exwb[31:0];
        if (r == 5'd0) return 32'd0;
        return m_rf[r];
    endfunction

    // One transaction: drive at negedge, push expectation, update model, compare after the edge.
    task automatic cycle(input string tag, input logic [31:0] pcv, input logic [31:0] ins,
                         input logic [70:0] exwb);
        logic [5:0]   op;
        logic [145:0] exp, got;
        logic         rw, def;
        logic [4:0]   dst;
        @(negedge clock);
        IF_ID = {pcv, ins};
        EX_WB = exwb;
        op  = ins[31:26];
        def = (op <= 6'd13);
        rw  = (op <= 6'd7) || (op >= 6'd10 && op <= 6'd12);
        dst = (op == 6'd11) ? ins[20:16] : ins[15:11];
        exp = '0;
        if (!m_halted && !exwb[70] && def)
            exp = {1'b1, rw, op, dst, ins[10:6], {{21{ins[10]}}, ins[10:0]},
                   m_operand(ins[20:16], exwb), m_operand(ins[25:21], exwb), pcv};
        exp_q.push_back(exp);
        if (!m_halted && !exwb[70] && op == 6'd13) m_halted = 1'b1;
        if (exwb[69] && exwb[68:64] != 5'd0) m_rf[exwb[68:64]] = exwb[31:0];
        @(posedge clock);
        #1;
        got = exp_q.pop_front();
        check(tag, ID_EX, got);
        check({tag, "_halted"}, 146'(halted), 146'(m_halted));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_halted = 1'b0;
    endtask

    initial begin
        model_reset();
        reset    = 1'b1;
        IF_ID    = '0;
        EX_WB    = '0;
        dbg_addr = '0;
        #12;
        check("reset_id_ex", ID_EX, '0);
        check("reset_halted", 146'(halted), '0);
        @(negedge clock);
        reset = 1'b0;

        // 1: writes then ADD $15,$2,$1
        cycle("wb1", 32'd0, NOP, wb(0, 1, 5'd1, 0, 32'd5));
        cycle("wb2", 32'd0, NOP, wb(0, 1, 5'd2, 0, 32'd7));
        cycle("add", 32'd0, rtype(6'd0, 5'd2, 5'd1, 5'd15), '0);
        check("add_hdr", 146'(ID_EX[145:133]), 146'({1'b1, 1'b1, 6'd0, 5'd15}));
        check("add_rs", 146'(ID_EX[63:32]), 146'd7);
        check("add_rt", 146'(ID_EX[95:64]), 146'd5);

        // 2: bypass
        cycle("bypass", 32'd4, rtype(6'd0, 5'd2, 5'd1, 5'd15), wb(0, 1, 5'd2, 0, 32'h99));
        check("bypass_rs", 146'(ID_EX[63:32]), 146'h99);
        dbg_addr = 5'd2;
        #1;
        check("dbg_r2", 146'(dbg_data), 146'h99);

        // 3: squash then BNE at target
        cycle("squash", 32'd8, rtype(6'd1, 5'd0, 5'd1, 5'd16), wb(1, 0, 0, 32'd14, 0));
        cycle("bne", 32'd14, itype(6'd9, 5'd1, 5'd2, 11'd6), '0);
        check("bne_imm", 146'(ID_EX[127:96]), 146'd6);
        check("bne_rw", 146'(ID_EX[144]), 146'd0);

        // 5: ADI, sign extension, $0 writes dropped, other opcodes
        cycle("adi", 32'd18, 32'h2C1A_0003, '0);
        check("adi_dest", 146'(ID_EX[137:133]), 146'd26);
        cycle("adi_neg", 32'd22, 32'h2C1A_07FF, '0);
        check("adi_imm", 146'(ID_EX[127:96]), 146'hFFFF_FFFF);
        cycle("wb_r0", 32'd26, NOP, wb(0, 1, 5'd0, 0, 32'h55));
        dbg_addr = 5'd0;
        #1;
        check("dbg_r0", 146'(dbg_data), '0);
        cycle("mul", 32'd30, rtype(6'd12, 5'd1, 5'd2, 5'd3), '0);
        cycle("mov", 32'd34, rtype(6'd10, 5'd2, 5'd0, 5'd4), '0);
        cycle("br", 32'd38, itype(6'd8, 5'd0, 5'd0, 11'h400), '0);
        cycle("undef", 32'd42, rtype(6'h3F, 5'd1, 5'd2, 5'd3), '0);
        cycle("op0f", 32'd46, rtype(6'h0F, 5'd1, 5'd2, 5'd3), '0);
        cycle("rand_xor", 32'd50, rtype(6'd7, 5'($urandom_range(1, 31)), 5'd2, 5'd9),
              wb(0, 1, 5'($urandom_range(1, 31)), 0, $urandom));

        // 4: HLT squashed by branch, then real HLT
        cycle("hlt_squash", 32'd54, HLT, wb(1, 0, 0, 32'd60, 0));
        cycle("hlt", 32'd60, HLT, '0);
        check("hlt_op", 146'(ID_EX[145:138]), 146'({1'b1, 1'b0, 6'b001101}));
        cycle("halted_add", 32'd64, rtype(6'd0, 5'd2, 5'd1, 5'd15), '0);
        cycle("halted_wb", 32'd68, rtype(6'd0, 5'd2, 5'd1, 5'd15), wb(0, 1, 5'd5, 0, 32'd3));
        dbg_addr = 5'd5;
        #1;
        check("dbg_r5", 146'(dbg_data), 146'd3);

        // 6: asynchronous reset between edges
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("areset_id_ex", ID_EX, '0);
        check("areset_halted", 146'(halted), '0);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            check($sformatf("areset_dbg%0d", a), 146'(dbg_data), '0);
        end
        @(negedge clock);
        EX_WB = '0;
        reset = 1'b0;
        cycle("post_reset_add", 32'd100, rtype(6'd0, 5'd2, 5'd1, 5'd15), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
